threshold_scan_scheduler: RTL and testbench
===========================================

Name: threshold_scan_scheduler

Overview:
- Sequences a threshold sweep for the multichannel counter board.
- For each step, it:
  - writes the threshold code to the SPI DAC;
  - waits a settle time;
  - clears the counter and opens its gate for a programmed window;
  - hands the 32 channel counts to the Ethernet/NIOS side with a readout handshake.
- Sits between the command decoder (configuration) and the spidac/counter/eth_top blocks, replacing the manual startStep/stopStep sequencing.

Parameters:
- THR_W, 16, width of threshold codes and step index.
- DAC_CMD, 16'h0030, upper half of the 32-bit DAC word, prepended to the threshold code.
- SETTLE_W, 24, width of the settle-time counter (clk cycles).
- WIN_W, 32, width of the gate-window counter (clk cycles).

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- cfg_start  in  1  single-cycle pulse; starts a sweep when idle
- cfg_abort  in  1  single-cycle pulse; aborts the sweep
- cfg_thr_start  in  THR_W  first threshold code
- cfg_thr_stop  in  THR_W  last threshold code (inclusive)
- cfg_thr_step  in  THR_W  increment between steps
- cfg_settle  in  SETTLE_W  DAC settle cycles
- cfg_window  in  WIN_W  gate length in cycles
- dac_wr  out  1  one-cycle write strobe to spidac
- dac_data  out  32  {DAC_CMD, cur_thr}
- dac_busy  in  1  high while the spidac shift is in progress
- cnt_clear  out  1  one-cycle counter clear
- cnt_gate  out  1  counter enable window
- rd_req  out  1  counts valid, readout requested
- rd_ack  in  1  host finished reading the counts
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- err  out  1  sticky config error; cleared by the next cfg_start
- cur_thr  out  THR_W  threshold of the current step
- step_idx  out  THR_W  zero-based step number

Behaviour:
- Reset: every output is 0; state is IDLE; the counters are 0.
- Configuration inputs are sampled on cfg_start into internal registers; later changes have no effect until the next sweep.
- States and transitions:
  - IDLE: on cfg_start, latch the configuration; cur_thr<=cfg_thr_start; step_idx<=0; err<=0; busy<=1.
    - If cfg_thr_start>cfg_thr_stop: err<=1, go to FINISH.
    - Otherwise go to DAC_WR.
  - DAC_WR: hold until dac_busy is low, then dac_wr=1 for one cycle and go to DAC_WAIT.
  - DAC_WAIT: wait one cycle for dac_busy to rise, then until it falls; go to SETTLE.
    - If dac_busy never rises within 4 cycles, continue anyway.
  - SETTLE: count cfg_settle cycles (0 means no wait); then cnt_clear=1 for one cycle and go to GATE.
  - GATE: cnt_gate=1 for exactly max(cfg_window,1) cycles; go to READOUT.
    - cnt_gate falls on the cycle after the last window cycle.
  - READOUT: rd_req=1; hold until rd_ack=1 is sampled; rd_req drops the following cycle; go to NEXT.
  - NEXT: nxt = cur_thr + max(cfg_thr_step,1), computed in THR_W+1 bits.
    - If nxt > cfg_thr_stop, or the carry bit is set: go to FINISH.
    - Otherwise cur_thr<=nxt, step_idx++, go to DAC_WR.
  - FINISH: done=1 for one cycle; busy<=0; go to IDLE.
- cfg_start while busy is ignored.
- cfg_abort in any non-IDLE state:
  - next cycle: IDLE, with busy, cnt_gate, rd_req and dac_wr low;
  - done is not pulsed; cur_thr and step_idx hold their values.
- cfg_abort and cfg_start in the same cycle while IDLE: abort wins, so the sweep does not start.
- rd_ack already high on entry to READOUT: accepted on the first cycle, so rd_req is high for 1 cycle.
- Latency from cfg_start to the first dac_wr: 2 cycles when dac_busy is low.
- Number of steps = floor((stop-start)/step)+1.

Optional Feature:
- Macro: SCAN_TIMESTAMP_EN.
- When defined:
  - a 32-bit free-running cycle counter (reset to 0) is added;
  - its value is latched on the first cycle of GATE into output step_ts[31:0], which is held until the next GATE;
  - step_ts is valid while rd_req is high.
- When undefined, step_ts and the counter do not exist.

Test Plan:
- Basic sweep: start=10, stop=30, step=10, settle=5, window=100; rd_ack returned 3 cycles after rd_req.
  - Expect 3 dac_wr with dac_data 0x0030000A, 0x00300014 and 0x0030001E.
  - Expect each cnt_gate high for exactly 100 cycles and step_idx 0,1,2, then a single done pulse with busy low.
- Inverted range: start=50, stop=20 → no dac_wr, err=1, done pulse 1 cycle after start.
- Wrap guard: start=16'hFFF0, stop=16'hFFFF, step=16'h0010 → exactly 1 step, then done.
- Zero-value config: step=0, window=0 on start=0, stop=2.
  - Expect 3 steps (thr 0,1,2), each with a cnt_gate width of 1 cycle.
- Abort during GATE at cycle 40 of 100 → next cycle cnt_gate=0, busy=0; no done, no rd_req; a following cfg_start runs normally.
- Reset mid-sweep: reset_n low during READOUT → all outputs 0 immediately (asynchronous); state IDLE after release.

Source files
------------

// File: rtl/threshold_scan_scheduler.sv
// ============================================================================
// Module   : threshold_scan_scheduler
// Purpose  : Steps a DAC threshold sweep: DAC write, settle, gated count,
//            readout handshake. Optional macro: SCAN_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module threshold_scan_scheduler #(
  parameter int          THR_W    = 16,
  parameter logic [15:0] DAC_CMD  = 16'h0030,
  parameter int          SETTLE_W = 24,
  parameter int          WIN_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [THR_W-1:0]    cfg_thr_start,
  input  logic [THR_W-1:0]    cfg_thr_stop,
  input  logic [THR_W-1:0]    cfg_thr_step,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [WIN_W-1:0]    cfg_window,
  output logic                dac_wr,
  output logic [31:0]         dac_data,
  input  logic                dac_busy,
  output logic                cnt_clear,
  output logic                cnt_gate,
  output logic                rd_req,
  input  logic                rd_ack,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [THR_W-1:0]    cur_thr,
`ifdef SCAN_TIMESTAMP_EN
  output logic [31:0]         step_ts,
`endif
  output logic [THR_W-1:0]    step_idx
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DAC_WR   = 3'd1,
    S_DAC_WAIT = 3'd2,
    S_SETTLE   = 3'd3,
    S_GATE     = 3'd4,
    S_READOUT  = 3'd5,
    S_NEXT     = 3'd6,
    S_FINISH   = 3'd7
  } state_t;

  localparam logic [THR_W-1:0] C_THR_ONE = {{(THR_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] C_WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       C_DAC_TIMEOUT = 3'd3;

  state_t              r_state;
  logic                r_dac_wr;
  logic [31:0]         r_dac_data;
  logic                r_cnt_clear;
  logic                r_cnt_gate;
  logic                r_rd_req;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [THR_W-1:0]    r_cur_thr;
  logic [THR_W-1:0]    r_step_idx;

  logic [THR_W-1:0]    r_thr_stop;
  logic [THR_W-1:0]    r_thr_step;
  logic [SETTLE_W-1:0] r_settle;
  logic [WIN_W-1:0]    r_window;

  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [2:0]          r_wait_cnt;
  logic                r_seen_busy;

  logic [THR_W-1:0]    w_step_eff;
  logic [WIN_W-1:0]    w_win_eff;
  logic [THR_W:0]      w_nxt;

  // Zero step/window would stall the sweep, so both are forced to at least 1.
  assign w_step_eff = (cfg_thr_step == '0) ? C_THR_ONE : cfg_thr_step;
  assign w_win_eff  = (cfg_window   == '0) ? C_WIN_ONE : cfg_window;
  assign w_nxt      = {1'b0, r_cur_thr} + {1'b0, r_thr_step};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dac_wr     <= 1'b0;
      r_dac_data   <= '0;
      r_cnt_clear  <= 1'b0;
      r_cnt_gate   <= 1'b0;
      r_rd_req     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cur_thr    <= '0;
      r_step_idx   <= '0;
      r_thr_stop   <= '0;
      r_thr_step   <= '0;
      r_settle     <= '0;
      r_window     <= '0;
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_seen_busy  <= 1'b0;
    end else begin
      r_dac_wr    <= 1'b0;
      r_done      <= 1'b0;
      r_cnt_clear <= 1'b0;
      if (cfg_abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_cnt_gate <= 1'b0;
        r_rd_req   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cfg_start && !cfg_abort) begin
              r_thr_stop <= cfg_thr_stop;
              r_thr_step <= w_step_eff;
              r_settle   <= cfg_settle;
              r_window   <= w_win_eff;
              r_cur_thr  <= cfg_thr_start;
              r_step_idx <= '0;
              if (cfg_thr_start > cfg_thr_stop) begin
                r_err   <= 1'b1;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_FINISH;
              end else begin
                r_err   <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_DAC_WR;
              end
            end
          end
          S_DAC_WR: begin
            if (!dac_busy) begin
              r_dac_wr    <= 1'b1;
              r_dac_data  <= {DAC_CMD, r_cur_thr};
              r_wait_cnt  <= '0;
              r_seen_busy <= 1'b0;
              r_state     <= S_DAC_WAIT;
            end
          end
          S_DAC_WAIT: begin
            // A spidac that never raises busy must not hang the sweep.
            if (r_seen_busy) begin
              if (!dac_busy) begin
                r_settle_cnt <= r_settle;
                r_state      <= S_SETTLE;
              end
            end else if (dac_busy) begin
              r_seen_busy <= 1'b1;
            end else if (r_wait_cnt == C_DAC_TIMEOUT) begin
              r_settle_cnt <= r_settle;
              r_state      <= S_SETTLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + 3'd1;
            end
          end
          S_SETTLE: begin
            if (r_settle_cnt == '0) begin
              r_cnt_clear <= 1'b1;
              r_win_cnt   <= r_window;
              r_state     <= S_GATE;
            end else begin
              r_settle_cnt <= r_settle_cnt - 1'b1;
            end
          end
          S_GATE: begin
            // First GATE cycle carries the clear; the gate opens after it.
            if (r_cnt_clear) begin
              r_cnt_gate <= 1'b1;
            end else if (r_win_cnt == C_WIN_ONE) begin
              r_cnt_gate <= 1'b0;
              r_rd_req   <= 1'b1;
              r_state    <= S_READOUT;
            end else begin
              r_win_cnt <= r_win_cnt - 1'b1;
            end
          end
          S_READOUT: begin
            if (rd_ack) begin
              r_rd_req <= 1'b0;
              r_state  <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (w_nxt[THR_W] || (w_nxt[THR_W-1:0] > r_thr_stop)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_cur_thr  <= w_nxt[THR_W-1:0];
              r_step_idx <= r_step_idx + C_THR_ONE;
              r_state    <= S_DAC_WR;
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SCAN_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;
  logic [31:0] r_step_ts;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts_cnt  <= '0;
      r_step_ts <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if ((r_state == S_GATE) && r_cnt_clear && !cfg_abort) begin
        r_step_ts <= r_ts_cnt;
      end
    end
  end

  assign step_ts = r_step_ts;
`endif

  assign dac_wr    = r_dac_wr;
  assign dac_data  = r_dac_data;
  assign cnt_clear = r_cnt_clear;
  assign cnt_gate  = r_cnt_gate;
  assign rd_req    = r_rd_req;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign cur_thr   = r_cur_thr;
  assign step_idx  = r_step_idx;

endmodule

`default_nettype wire

// File: tb/tb_threshold_scan_scheduler.sv
// ============================================================================
// Module   : tb_threshold_scan_scheduler
// Purpose  : Directed self-checking bench for threshold_scan_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_threshold_scan_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start, cfg_abort;
  logic [15:0] cfg_thr_start, cfg_thr_stop, cfg_thr_step;
  logic [23:0] cfg_settle;
  logic [31:0] cfg_window;
  logic        dac_wr, dac_busy, cnt_clear, cnt_gate, rd_req, rd_ack;
  logic        busy, done, err;
  logic [31:0] dac_data;
  logic [15:0] cur_thr, step_idx;
`ifdef SCAN_TIMESTAMP_EN
  logic [31:0] step_ts;
`endif

  always #5 clk = ~clk;

  threshold_scan_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_thr_start(cfg_thr_start), .cfg_thr_stop(cfg_thr_stop),
    .cfg_thr_step(cfg_thr_step), .cfg_settle(cfg_settle), .cfg_window(cfg_window),
    .dac_wr(dac_wr), .dac_data(dac_data), .dac_busy(dac_busy),
    .cnt_clear(cnt_clear), .cnt_gate(cnt_gate),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .busy(busy), .done(done), .err(err),
    .cur_thr(cur_thr),
`ifdef SCAN_TIMESTAMP_EN
    .step_ts(step_ts),
`endif
    .step_idx(step_idx)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event log, sampled on the falling edge
  int          n_wr, n_gate, n_done, n_rdreq, gate_run;
  logic [31:0] wr_log   [0:7];
  int          gw_log   [0:7];
  logic [15:0] sidx_log [0:7];

  always @(negedge clk) begin
    if (dac_wr) begin
      if (n_wr < 8) wr_log[n_wr] = dac_data;
      n_wr++;
    end
    if (cnt_gate) gate_run++;
    else if (gate_run > 0) begin
      if (n_gate < 8) begin
        gw_log[n_gate]   = gate_run;
        sidx_log[n_gate] = step_idx;
      end
      n_gate++;
      gate_run = 0;
    end
    if (done)   n_done++;
    if (rd_req) n_rdreq++;
  end

  // spidac model: busy for 4 cycles after each write strobe
  int bcnt = 0;
  always @(negedge clk) begin
    if (dac_wr) bcnt = 4;
    else if (bcnt > 0) bcnt--;
    dac_busy = (bcnt > 0);
  end

  // host model: one-cycle ack 3 cycles after rd_req rises
  int adly = 0;
  always @(negedge clk) begin
    if (rd_ack) rd_ack = 1'b0;
    else if (rd_req) begin
      adly++;
      if (adly == 3) rd_ack = 1'b1;
    end else adly = 0;
  end

  task automatic clear_log();
    n_wr = 0; n_gate = 0; n_done = 0; n_rdreq = 0; gate_run = 0;
  endtask

  // Returns on the first falling edge after the start pulse was sampled.
  task automatic start_sweep(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                             input logic [23:0] se, input logic [31:0] w);
    @(negedge clk);
    cfg_thr_start = s; cfg_thr_stop = e; cfg_thr_step = st;
    cfg_settle = se; cfg_window = w; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int   i = 0;
    logic got = 1'b0;
    while (!got && i < budget) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
      i++;
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_thr_start = '0; cfg_thr_stop = '0; cfg_thr_step = '0;
    cfg_settle = '0; cfg_window = '0; dac_busy = 1'b0; rd_ack = 1'b0;
    clear_log();
    #1;
    check("rst_outputs", {dac_wr, cnt_clear, cnt_gate, rd_req, busy, done, err}, 32'd0);
    check("rst_thr_idx", {cur_thr, step_idx}, 32'd0);
    check("rst_dac_data", dac_data, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Basic sweep with first-write latency
    clear_log();
    start_sweep(16'd10, 16'd30, 16'd10, 24'd5, 32'd100);
    check("t1_lat_wr_early", {31'd0, dac_wr}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cur_thr", {16'd0, cur_thr}, 32'd10);
    @(negedge clk);
    check("t1_lat_wr", {31'd0, dac_wr}, 32'd1);
    wait_done("t1", 2000);
    check("t1_n_wr", n_wr, 32'd3);
    check("t1_wr0", wr_log[0], 32'h0030000A);
    check("t1_wr1", wr_log[1], 32'h00300014);
    check("t1_wr2", wr_log[2], 32'h0030001E);
    check("t1_n_gate", n_gate, 32'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t1_gate_w%0d", k), gw_log[k], 32'd100);
      check($sformatf("t1_sidx%0d", k), {16'd0, sidx_log[k]}, k);
    end
    check("t1_n_done", n_done, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);

    // Inverted range
    clear_log();
    start_sweep(16'd50, 16'd20, 16'd1, 24'd0, 32'd5);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("t2_done_pulse", {31'd0, done}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t2_n_wr", n_wr, 32'd0);
    check("t2_err_sticky", {31'd0, err}, 32'd1);

    // Wrap guard
    clear_log();
    start_sweep(16'hFFF0, 16'hFFFF, 16'h0010, 24'd2, 32'd3);
    check("t3_err_cleared", {31'd0, err}, 32'd0);
    wait_done("t3", 500);
    check("t3_n_wr", n_wr, 32'd1);
    check("t3_wr0", wr_log[0], 32'h0030FFF0);

    // Zero step / zero window
    clear_log();
    start_sweep(16'd0, 16'd2, 16'd0, 24'd0, 32'd0);
    wait_done("t4", 500);
    check("t4_n_wr", n_wr, 32'd3);
    check("t4_wr2", wr_log[2], 32'h00300002);
    check("t4_n_gate", n_gate, 32'd3);
    for (int k = 0; k < 3; k++) check($sformatf("t4_gate_w%0d", k), gw_log[k], 32'd1);

    // Abort during gate cycle 40
    clear_log();
    start_sweep(16'd10, 16'd30, 16'd10, 24'd5, 32'd100);
    begin
      int i = 0;
      while (!cnt_gate && i < 100) begin @(negedge clk); i++; end
      check("t5_gate_seen", {31'd0, cnt_gate}, 32'd1);
    end
    repeat (39) @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    check("t5_gate_off", {31'd0, cnt_gate}, 32'd0);
    check("t5_busy_off", {31'd0, busy}, 32'd0);
    check("t5_thr_hold", {cur_thr, step_idx}, {16'd10, 16'd0});
    repeat (6) @(negedge clk);
    check("t5_no_done", n_done, 32'd0);
    check("t5_no_rdreq", n_rdreq, 32'd0);
    clear_log();
    start_sweep(16'd0, 16'd2, 16'd1, 24'd1, 32'd3);
    wait_done("t5b", 500);
    check("t5b_n_wr", n_wr, 32'd3);

    // Abort wins over start in IDLE
    clear_log();
    @(negedge clk);
    cfg_start = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_abort = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("t6_n_wr", n_wr, 32'd0);

    // Asynchronous reset during readout
    start_sweep(16'd5, 16'd9, 16'd1, 24'd0, 32'd4);
    begin
      int i = 0;
      while (!rd_req && i < 100) begin @(negedge clk); i++; end
      check("t7_rdreq_seen", {31'd0, rd_req}, 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    check("t7_async_ctl", {dac_wr, cnt_clear, cnt_gate, rd_req, busy, done, err}, 32'd0);
    check("t7_async_thr", {cur_thr, step_idx}, 32'd0);
    check("t7_async_data", dac_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t7_idle", {31'd0, busy}, 32'd0);
    clear_log();
    start_sweep(16'd7, 16'd7, 16'd1, 24'd0, 32'd2);
    wait_done("t7b", 500);
    check("t7b_wr0", wr_log[0], 32'h00300007);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
